chess_board_renderer: RTL

Streams the chessboard to the LCD pixel interface. It consumes the flattened 64×8-bit `Layout` bus produced by the layout-matrix stage and walks every pixel of the 240×320 panel in raster order. For each pixel it computes an RGB565 colour from the square's contents and highlight bits, then hands it to the LCD driver over a write/ready handshake. `Layout` is snapshotted once per frame so that a frame never shows a half-applied move.

---
 rtl/chess_board_renderer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/chess_board_renderer.sv
// Raster-scans the LCD panel and emits one RGB565 pixel per handshake beat, painting the chessboard from a
// per-frame snapshot of the layout bus. Square position comes from per-axis sub-counters, so no divider is needed.
module chess_board_renderer #(
    parameter int          LCD_WIDTH     = 240,
    parameter int          LCD_HEIGHT    = 320,
    parameter int          SQUARE_PIXELS = 30,
    parameter int          BOARD_X0      = 0,
    parameter int          BOARD_Y0      = 40,
    parameter int          BORDER        = 2,
    parameter logic [15:0] LIGHT_COLOUR  = 16'hFFDF,
    parameter logic [15:0] DARK_COLOUR   = 16'h8A22,
    parameter logic [15:0] WHITE_PIECE   = 16'hFFFF,
    parameter logic [15:0] BLACK_PIECE   = 16'h0000,
    parameter logic [15:0] CURSOR_COLOUR = 16'h07E0,
    parameter logic [15:0] LOCK_COLOUR   = 16'hF800,
    parameter logic [15:0] TARGET_COLOUR = 16'h001F,
    parameter logic [15:0] BACKGROUND    = 16'h2104
) (
    input  logic         clock,
    input  logic         resetApp,
    input  logic         RenderEnable,
    input  logic [511:0] Layout,
    input  logic         pixelReady,
    output logic [7:0]   xAddr,
    output logic [8:0]   yAddr,
    output logic [15:0]  pixelData,
    output logic         pixelWrite,
    output logic         FrameDone
);

    // state  | meaning
    // IDLE   | no frame in progress, waiting for RenderEnable
    // LATCH  | snapshot Layout, clear counters, load pixel (0,0)
    // STREAM | pixel beats offered to the LCD driver
    // DONE   | one-cycle FrameDone pulse
    typedef enum logic [1:0] {IDLE, LATCH, STREAM, DONE} renderState;

    localparam int              LW         = (SQUARE_PIXELS > 2) ? $clog2(SQUARE_PIXELS) : 1;
    localparam int              BOARD_SPAN = 8 * SQUARE_PIXELS;
    localparam logic [7:0]      X_LAST     = 8'(LCD_WIDTH - 1);
    localparam logic [8:0]      Y_LAST     = 9'(LCD_HEIGHT - 1);
    localparam logic [LW-1:0]   LOCAL_LAST = LW'(SQUARE_PIXELS - 1);

    renderState    state, nextState;
    logic [511:0]  snapshot, colSrc;
    logic [LW-1:0] localX, localY, nextLocalX, nextLocalY, colLocalX, colLocalY;
    logic [2:0]    sqX, sqY, nextSqX, nextSqY, colSqX, colSqY;
    logic [7:0]    nextX, colX;
    logic [8:0]    nextY, colY;
    logic          accept, lastCol, lastPixel, inBoardX, inBoardY;
    logic [15:0]   nextColour;

    function automatic logic [15:0] colourOf(
        input logic [7:0]    px,
        input logic [8:0]    py,
        input logic [LW-1:0] lx,
        input logic [2:0]    sx,
        input logic [LW-1:0] ly,
        input logic [2:0]    sy,
        input logic [511:0]  src
    );
        logic [6:0] sqv;
        logic [2:0] man;
        logic       onBoard, border, piece;
        int         lxi, lyi, inset;
        sqv     = src[{sy, sx, 3'b000} +: 7];
        man     = sqv[2:0];
        lxi     = int'(lx);
        lyi     = int'(ly);
        inset   = 14 - 2 * int'(man);
        onBoard = int'(px) >= BOARD_X0 && int'(px) < BOARD_X0 + BOARD_SPAN &&
                  int'(py) >= BOARD_Y0 && int'(py) < BOARD_Y0 + BOARD_SPAN;
        border  = lxi < BORDER || lyi < BORDER ||
                  lxi >= SQUARE_PIXELS - BORDER || lyi >= SQUARE_PIXELS - BORDER;
        piece   = man != 3'd0 && man != 3'd7 &&
                  lxi >= inset && lxi <= SQUARE_PIXELS - 1 - inset &&
                  lyi >= inset && lyi <= SQUARE_PIXELS - 1 - inset;
        if (!onBoard)
            colourOf = BACKGROUND;
        else if (border && sqv[5])
            colourOf = LOCK_COLOUR;
        else if (border && sqv[6])
            colourOf = TARGET_COLOUR;
        else if (border && sqv[4])
            colourOf = CURSOR_COLOUR;
        else if (piece)
            colourOf = sqv[3] ? WHITE_PIECE : BLACK_PIECE;
        else
            colourOf = (sx[0] ^ sy[0]) ? DARK_COLOUR : LIGHT_COLOUR;
    endfunction

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        accept    = pixelWrite & pixelReady;
        lastCol   = xAddr == X_LAST;
        lastPixel = lastCol && yAddr == Y_LAST;
        nextState = state;
        case (state)
            IDLE:    if (RenderEnable) nextState = LATCH;
            LATCH:   nextState = STREAM;
            STREAM:  if (accept && lastPixel) nextState = DONE;
            DONE:    nextState = RenderEnable ? LATCH : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Sub-counters hold the in-square position of the current pixel; they only move while on the board.
    always_comb begin
        inBoardX   = int'(xAddr) >= BOARD_X0 && int'(xAddr) < BOARD_X0 + BOARD_SPAN;
        inBoardY   = int'(yAddr) >= BOARD_Y0 && int'(yAddr) < BOARD_Y0 + BOARD_SPAN;
        nextX      = xAddr + 8'd1;
        nextY      = yAddr;
        nextLocalX = localX;
        nextSqX    = sqX;
        nextLocalY = localY;
        nextSqY    = sqY;
        if (inBoardX) begin
            if (localX == LOCAL_LAST) begin
                nextLocalX = '0;
                nextSqX    = sqX + 3'd1;
            end else begin
                nextLocalX = localX + LW'(1);
            end
        end
        if (lastCol) begin
            nextX      = '0;
            nextY      = yAddr + 9'd1;
            nextLocalX = '0;
            nextSqX    = '0;
            if (inBoardY) begin
                if (localY == LOCAL_LAST) begin
                    nextLocalY = '0;
                    nextSqY    = sqY + 3'd1;
                end else begin
                    nextLocalY = localY + LW'(1);
                end
            end
        end
    end

    // In LATCH the snapshot is still being loaded, so pixel (0,0) is coloured straight from Layout.
    always_comb begin
        if (state == LATCH) begin
            colX      = '0;
            colY      = '0;
            colLocalX = '0;
            colSqX    = '0;
            colLocalY = '0;
            colSqY    = '0;
            colSrc    = Layout;
        end else begin
            colX      = nextX;
            colY      = nextY;
            colLocalX = nextLocalX;
            colSqX    = nextSqX;
            colLocalY = nextLocalY;
            colSqY    = nextSqY;
            colSrc    = snapshot;
        end
        nextColour = colourOf(colX, colY, colLocalX, colSqX, colLocalY, colSqY, colSrc);
    end

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            snapshot   <= '0;
            xAddr      <= '0;
            yAddr      <= '0;
            localX     <= '0;
            sqX        <= '0;
            localY     <= '0;
            sqY        <= '0;
            pixelData  <= '0;
            pixelWrite <= 1'b0;
            FrameDone  <= 1'b0;
        end else begin
            case (state)
                LATCH: begin
                    snapshot  <= Layout;
                    xAddr     <= '0;
                    yAddr     <= '0;
                    localX    <= '0;
                    sqX       <= '0;
                    localY    <= '0;
                    sqY       <= '0;
                    pixelData <= nextColour;
                end
                STREAM: begin
                    if (accept && !lastPixel) begin
                        xAddr     <= nextX;
                        yAddr     <= nextY;
                        localX    <= nextLocalX;
                        sqX       <= nextSqX;
                        localY    <= nextLocalY;
                        sqY       <= nextSqY;
                        pixelData <= nextColour;
                    end
                end
                default: ;
            endcase
            pixelWrite <= nextState == STREAM;
            FrameDone  <= nextState == DONE;
        end
    end

endmodule
